// File: rtl/pattern_generator_if.sv
// AXI4-Stream video pixel channel between the pattern source and its sink.
interface pattern_generator_if #(
    parameter int unsigned DATA_W = 24
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/pattern_generator.sv
// Parametrised AXI4-Stream video test pattern source with frame-boundary shadowed config.
module pattern_generator #(
    parameter int unsigned X_SIZE   = 640,
    parameter int unsigned Y_SIZE   = 480,
    parameter int unsigned CH_WIDTH = 8,
    parameter int unsigned NUM_CH   = 3
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                cfg_wr,
    input  logic [1:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    pattern_generator_if.master out_stream,
    output logic [15:0]         frame_count,
    output logic                busy
);
    localparam int unsigned DATA_W = NUM_CH * CH_WIDTH;
    localparam int unsigned XW     = $clog2(X_SIZE);
    localparam int unsigned YW     = $clog2(Y_SIZE);
    localparam int unsigned CW8    = (CH_WIDTH < 8) ? CH_WIDTH : 8;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [15:0]       frame_q, frame_d, sh_frame_q, sh_frame_d;
    logic [1:0]        mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic [31:0]       colour_q, colour_d, sh_colour_q, sh_colour_d;
    logic [2:0]        check_q, check_d, sh_check_q, sh_check_d;
    logic              enable_q, enable_d, auto_inc_q, auto_inc_d;
    logic              last_x_c, last_y_c, hs_c, frame_end_c, start_c, load_c;
    logic [DATA_W-1:0] pix_d;

    // Pixel value for a position under a given (shadow) configuration.
    function automatic logic [DATA_W-1:0] pixel(
        input logic [XW-1:0] px,
        input logic [YW-1:0] py,
        input logic [15:0]   f,
        input logic [1:0]    m,
        input logic [31:0]   col,
        input logic [2:0]    chk
    );
        logic [DATA_W-1:0]   p;
        logic [CH_WIDTH-1:0] cx, cy, cf, ch, ones;
        logic [2:0]          bar, inv;
        logic [7:0]          xe, ye;
        logic                s;
        p    = '0;
        ch   = '0;
        ones = '1;
        cx   = CH_WIDTH'(px);
        cy   = CH_WIDTH'(py);
        cf   = CH_WIDTH'(f);
        // Bar index: number of boundaries ceil(k*X/8) already passed, equals floor(8x/X).
        bar = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(px) >= (k * X_SIZE + 7) / 8) begin
                bar = bar + 3'd1;
            end
        end
        inv = 3'd7 - bar;
        // Bits above the counter width read as zero through the zero-extension.
        xe = 8'(px);
        ye = 8'(py);
        s  = xe[chk] ^ ye[chk] ^ f[0];
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            case (m)
                2'd0: begin
                    if (c == 0)      ch = cx + cf;
                    else if (c == 1) ch = cy + cf;
                    else             ch = cx + cy + cf;
                end
                2'd1:    ch = CH_WIDTH'(CW8'(col >> (8 * c)));
                2'd2:    ch = inv[2'(c % 3)] ? ones : '0;
                default: ch = s ? ones : '0;
            endcase
            p = p | (DATA_W'(ch) << (c * CH_WIDTH));
        end
        return p;
    endfunction

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: enable is only looked at when a frame would start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_q) state_d = ST_RUN;
            ST_RUN:  if (frame_end_c && !enable_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake/frame strobes and next pixel position.
    always_comb begin
        last_x_c    = (x_q == XW'(X_SIZE - 1));
        last_y_c    = (y_q == YW'(Y_SIZE - 1));
        hs_c        = (state_q == ST_RUN) && out_stream.tready;
        frame_end_c = hs_c && last_x_c && last_y_c;
        start_c     = (state_q == ST_IDLE) && enable_q;
        load_c      = start_c || (frame_end_c && enable_q);
        x_d         = x_q;
        y_d         = y_q;
        if (load_c || frame_end_c) begin
            x_d = '0;
            y_d = '0;
        end else if (hs_c) begin
            if (last_x_c) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Live register writes; a cfg write to FRAME beats the auto-increment.
    always_comb begin
        frame_d    = frame_q;
        mode_d     = mode_q;
        colour_d   = colour_q;
        enable_d   = enable_q;
        auto_inc_d = auto_inc_q;
        check_d    = check_q;
        if (frame_end_c && auto_inc_q) frame_d = frame_q + 16'd1;
        if (cfg_wr) begin
            case (cfg_addr)
                2'd0: frame_d  = cfg_wdata[15:0];
                2'd1: mode_d   = cfg_wdata[1:0];
                2'd2: colour_d = cfg_wdata;
                default: begin
                    enable_d   = cfg_wdata[0];
                    auto_inc_d = cfg_wdata[1];
                    check_d    = cfg_wdata[6:4];
                end
            endcase
        end
    end

    // Shadows capture the post-update live values so an auto-incremented FRAME applies to the new frame.
    always_comb begin
        sh_frame_d  = load_c ? frame_d  : sh_frame_q;
        sh_mode_d   = load_c ? mode_d   : sh_mode_q;
        sh_colour_d = load_c ? colour_d : sh_colour_q;
        sh_check_d  = load_c ? check_d  : sh_check_q;
        pix_d       = pixel(x_d, y_d, sh_frame_d, sh_mode_d, sh_colour_d, sh_check_d);
    end

    // Counters, live and shadow registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            x_q         <= '0;
            y_q         <= '0;
            frame_q     <= '0;
            mode_q      <= '0;
            colour_q    <= '0;
            enable_q    <= 1'b0;
            auto_inc_q  <= 1'b0;
            check_q     <= '0;
            sh_frame_q  <= '0;
            sh_mode_q   <= '0;
            sh_colour_q <= '0;
            sh_check_q  <= '0;
            frame_count <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            frame_q     <= frame_d;
            mode_q      <= mode_d;
            colour_q    <= colour_d;
            enable_q    <= enable_d;
            auto_inc_q  <= auto_inc_d;
            check_q     <= check_d;
            sh_frame_q  <= sh_frame_d;
            sh_mode_q   <= sh_mode_d;
            sh_colour_q <= sh_colour_d;
            sh_check_q  <= sh_check_d;
            if (frame_end_c) frame_count <= frame_count + 16'd1;
        end
    end

    // Registered stream outputs; payload only moves on frame start or handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_stream.tvalid <= 1'b0;
            out_stream.tdata  <= '0;
            out_stream.tlast  <= 1'b0;
            out_stream.tuser  <= 1'b0;
            busy              <= 1'b0;
        end else begin
            out_stream.tvalid <= (state_d == ST_RUN);
            busy              <= (state_d == ST_RUN);
            if (load_c || hs_c) begin
                if (state_d == ST_RUN) begin
                    out_stream.tdata <= pix_d;
                    out_stream.tlast <= (x_d == XW'(X_SIZE - 1));
                    out_stream.tuser <= (x_d == '0) && (y_d == '0);
                end else begin
                    out_stream.tdata <= '0;
                    out_stream.tlast <= 1'b0;
                    out_stream.tuser <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pattern_generator.sv
// Scoreboard bench for pattern_generator: expected beats queued per frame, monitor pops on handshake.
module tb_pattern_generator;
    localparam int unsigned X_SIZE      = 640;
    localparam int unsigned Y_SIZE      = 2;
    localparam int unsigned CH_WIDTH    = 8;
    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned DATA_W      = NUM_CH * CH_WIDTH;
    localparam int unsigned FRAME_BEATS = X_SIZE * Y_SIZE;
    localparam int unsigned WAIT_LIMIT  = 10000;

    typedef struct packed {
        logic [23:0] data;
        logic        last;
        logic        user;
        logic [15:0] fc;
    } beat_t;

    logic        aclk      = 1'b0;
    logic        areset    = 1'b1;
    logic        cfg_wr    = 1'b0;
    logic [1:0]  cfg_addr  = 2'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [15:0] frame_count;
    logic        busy;

    pattern_generator_if #(.DATA_W(DATA_W)) out_stream ();

    pattern_generator #(
        .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .CH_WIDTH(CH_WIDTH), .NUM_CH(NUM_CH)
    ) dut (
        .aclk(aclk), .areset(areset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .out_stream(out_stream),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int unsigned checks    = 0;
    int unsigned failures  = 0;
    int unsigned sof_seen  = 0;
    int unsigned beat_idx  = 0;
    bit          bp_en     = 1'b0;
    bit          skip_len  = 1'b1;
    bit          hold_pend = 1'b0;
    logic [25:0] held;
    beat_t       exp_q[$];
    logic [24:0] cap0[16];
    logic [24:0] cap80[16];
    logic [24:0] cap639[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [23:0] model_pixel(input int unsigned x, input int unsigned y,
                                                input int unsigned f, input int unsigned mode,
                                                input logic [31:0] col, input int unsigned chk);
        logic [7:0]  ch [3];
        int unsigned b;
        int unsigned s;
        for (int unsigned c = 0; c < 3; c++) begin
            case (mode)
                0: begin
                    if (c == 0)      ch[c] = 8'(x + f);
                    else if (c == 1) ch[c] = 8'(y + f);
                    else             ch[c] = 8'(x + y + f);
                end
                1: ch[c] = 8'(col >> (8 * c));
                2: begin
                    b     = (8 * x) / X_SIZE;
                    ch[c] = (((7 - b) >> c) & 1) != 0 ? 8'hFF : 8'h00;
                end
                default: begin
                    s     = ((x >> chk) ^ (y >> chk) ^ f) & 1;
                    ch[c] = (s != 0) ? 8'hFF : 8'h00;
                end
            endcase
        end
        return {ch[2], ch[1], ch[0]};
    endfunction

    task automatic push_frame(input int unsigned f, input int unsigned mode, input logic [31:0] col,
                              input int unsigned chk, input int unsigned fc);
        beat_t b;
        for (int unsigned y = 0; y < Y_SIZE; y++) begin
            for (int unsigned x = 0; x < X_SIZE; x++) begin
                b.data = model_pixel(x, y, f, mode, col, chk);
                b.last = (x == X_SIZE - 1);
                b.user = (x == 0) && (y == 0);
                b.fc   = 16'(fc);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge aclk); #1;
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge aclk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic wait_sof(input int unsigned n);
        int unsigned cyc = 0;
        while (sof_seen < n && cyc < WAIT_LIMIT) begin
            @(posedge aclk);
            cyc++;
        end
        #1;
        check($sformatf("wait_sof_%0d", n), 64'(sof_seen >= n), 64'd1);
    endtask

    task automatic wait_idle();
        int unsigned cyc = 0;
        while (busy !== 1'b0 && cyc < WAIT_LIMIT) begin
            @(posedge aclk);
            cyc++;
        end
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_tvalid", 64'(out_stream.tvalid), 64'd0);
        check("idle_queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Downstream ready: constant high or pseudo-random backpressure.
    initial begin
        out_stream.tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            out_stream.tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: pops an expected beat per handshake and checks AXI hold stability.
    always @(negedge aclk) begin
        beat_t e;
        if (!areset) begin
            if (hold_pend)
                check("axi_hold", 64'({out_stream.tdata, out_stream.tlast, out_stream.tuser}), 64'(held));
            if (out_stream.tvalid && out_stream.tready) begin
                if (out_stream.tuser) begin
                    if (!skip_len) check("frame_beats", 64'(beat_idx), 64'(FRAME_BEATS));
                    skip_len = 1'b0;
                    beat_idx = 0;
                    sof_seen++;
                end
                if (sof_seen < 16) begin
                    if (beat_idx == 0)   cap0[sof_seen]   = {out_stream.tlast, out_stream.tdata};
                    if (beat_idx == 80)  cap80[sof_seen]  = {out_stream.tlast, out_stream.tdata};
                    if (beat_idx == 639) cap639[sof_seen] = {out_stream.tlast, out_stream.tdata};
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected actual tdata=0x%0h required no beat", out_stream.tdata);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat_f%0d_i%0d", sof_seen, beat_idx),
                          64'({out_stream.tdata, out_stream.tlast, out_stream.tuser}),
                          64'({e.data, e.last, e.user}));
                    if (e.user) check($sformatf("frame_count_f%0d", sof_seen), 64'(frame_count), 64'(e.fc));
                end
                beat_idx++;
            end
            hold_pend = out_stream.tvalid && !out_stream.tready;
            held      = {out_stream.tdata, out_stream.tlast, out_stream.tuser};
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        check("rst_tvalid", 64'(out_stream.tvalid), 64'd0);
        check("rst_tdata", 64'(out_stream.tdata), 64'd0);
        check("rst_tlast_tuser", 64'({out_stream.tlast, out_stream.tuser}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);

        // Frame 1: gradient, FRAME=5; check enable-to-first-beat latency.
        cfg_write(2'd0, 32'd5);
        cfg_write(2'd1, 32'd0);
        push_frame(5, 0, 32'd0, 0, 0);
        @(posedge aclk); #1;
        cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'h1;
        @(posedge aclk); #1;
        cfg_wr = 1'b0;
        check("en_edge1_tvalid", 64'(out_stream.tvalid), 64'd0);
        @(posedge aclk); #1;
        check("en_edge2_tvalid", 64'(out_stream.tvalid), 64'd1);
        check("en_edge2_tuser", 64'(out_stream.tuser), 64'd1);

        // Frame 2: solid 0xAABBCC.
        wait_sof(1);
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd2, 32'h00AABBCC);
        push_frame(5, 1, 32'h00AABBCC, 0, 1);

        // Frame 3: colour changed mid frame 2 only shows from frame 3.
        wait_sof(2);
        check("grad_beat0", 64'(cap0[1]), 64'h0_050505);
        check("grad_beat639", 64'(cap639[1]), 64'h1_840584);
        cfg_write(2'd2, 32'h00112233);
        push_frame(5, 1, 32'h00112233, 0, 2);

        // Frame 4: colour bars under backpressure.
        wait_sof(3);
        check("shadow_old_colour", 64'(cap639[2]), 64'h1_AABBCC);
        check("shadow_new_colour", 64'(cap0[3]), 64'h0_112233);
        cfg_write(2'd1, 32'd2);
        push_frame(5, 2, 32'h00112233, 0, 3);

        // Frame 5: checker, CHECK_LOG2=0, FRAME=7.
        wait_sof(4);
        bp_en = 1'b1;
        cfg_write(2'd0, 32'd7);
        cfg_write(2'd1, 32'd3);
        cfg_write(2'd3, 32'h01);
        push_frame(7, 3, 32'h00112233, 0, 4);

        // Frame 6: checker, CHECK_LOG2=3 (beyond the y counter width).
        wait_sof(5);
        check("bars_x0", 64'(cap0[4]), 64'h0_FFFFFF);
        check("bars_x80", 64'(cap80[4]), 64'h0_FFFF00);
        check("bars_x639", 64'(cap639[4]), 64'h1_000000);
        cfg_write(2'd3, 32'h31);
        push_frame(7, 3, 32'h00112233, 3, 5);

        // Stop after frame 6.
        wait_sof(6);
        bp_en = 1'b0;
        cfg_write(2'd3, 32'h30);
        wait_idle();
        check("stop_frame_count", 64'(frame_count), 64'd6);

        // Frames 7..9: AUTO_INC from FRAME=1, cleared mid frame 9.
        cfg_write(2'd0, 32'd1);
        cfg_write(2'd1, 32'd0);
        push_frame(1, 0, 32'd0, 0, 6);
        push_frame(2, 0, 32'd0, 0, 7);
        push_frame(3, 0, 32'd0, 0, 8);
        cfg_write(2'd3, 32'h3);
        wait_sof(9);
        cfg_write(2'd3, 32'h0);
        wait_idle();
        check("autoinc_frame_count", 64'(frame_count), 64'd9);
        check("autoinc_f1", 64'(cap0[7]), 64'h0_010101);
        check("autoinc_f2", 64'(cap0[8]), 64'h0_020202);
        check("autoinc_f3", 64'(cap0[9]), 64'h0_030303);

        // Frame 10 aborted by reset mid frame.
        push_frame(3, 0, 32'd0, 0, 9);
        cfg_write(2'd3, 32'h1);
        wait_sof(10);
        repeat (100) @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        check("mid_rst_tvalid", 64'(out_stream.tvalid), 64'd0);
        check("mid_rst_tdata", 64'(out_stream.tdata), 64'd0);
        check("mid_rst_tlast_tuser", 64'({out_stream.tlast, out_stream.tuser}), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_frame_count", 64'(frame_count), 64'd0);
        exp_q.delete();
        skip_len = 1'b1;

        // Frame 11: live registers cleared, so gradient with FRAME=0 from (0,0).
        push_frame(0, 0, 32'd0, 0, 0);
        cfg_write(2'd3, 32'h1);
        wait_sof(11);
        check("post_rst_first_beat", 64'(cap0[11]), 64'h0_000000);
        cfg_write(2'd3, 32'h0);
        wait_idle();
        check("post_rst_frame_count", 64'(frame_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
